// File: rtl/mem_bram_responder.sv
// Block-RAM stand-in for the MIG/DDR3 pair: serves da_platform MemoryCommand bursts on clk_mem.
// Build option MEM_RESPONDER_BOUNDS_CHECK_EN adds range checking and the sticky addr_error port.
module mem_bram_responder #(
  parameter int mem_width     = 32,
  parameter int mem_log_depth = 12
) (
  input  logic                 clk_mem,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [64:0]          cmd_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [mem_width-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [mem_width-1:0] rd_data,
  output logic                 busy
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  ,
  output logic                 addr_error
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                   state, next_state;
  logic [31:0]              addr_q, len_q, idx_q;
  logic [mem_log_depth-1:0] mem_idx;
  logic                     cmd_fire, wr_fire, rd_fire, issue, last_word, mem_we;
  logic [1:0]               cnt_q;
  logic                     pend_q;
  logic [2:0]               occupancy;
  logic [mem_width-1:0]     ram_q, push_data, skid_q;
  logic [mem_width-1:0]     mem [1 << mem_log_depth];

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign rd_valid  = (cnt_q != 2'd0);
  assign last_word = (idx_q == len_q - 32'd1);

  // Words held plus the one in flight from the BRAM never exceed the two skid entries.
  assign occupancy = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, rd_fire};
  assign issue     = (state == READ) && (occupancy < 3'd2);

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  logic [32:0] word_addr;
  logic        oob, pend_oob_q;

  assign word_addr = {1'b0, addr_q} + {1'b0, idx_q};
  assign oob       = (word_addr >> mem_log_depth) != 33'd0;
  assign mem_idx   = word_addr[mem_log_depth-1:0];
  assign mem_we    = wr_fire && !oob;
  assign push_data = pend_oob_q ? '0 : ram_q;

  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      pend_oob_q <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      if (issue) pend_oob_q <= oob;
      if ((wr_fire || issue) && oob) addr_error <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^addr_q[31:mem_log_depth];
  assign mem_idx        = addr_q[mem_log_depth-1:0] + idx_q[mem_log_depth-1:0];
  assign mem_we         = wr_fire;
  assign push_data      = ram_q;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (cmd_fire && (cmd_data[31:0] != 32'd0)) next_state = cmd_data[64] ? READ : WRITE;
      WRITE: if (wr_fire && last_word) next_state = IDLE;
      READ:  if (issue && last_word) next_state = DRAIN;
      DRAIN: if ((cnt_q == 2'd0) && !pend_q) next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      // The final write beat gets one settling cycle before the next command is taken.
      cmd_ready <= (next_state == IDLE) && !(wr_fire && last_word);
      wr_ready  <= (next_state == WRITE);
      busy      <= (next_state != IDLE);
    end
  end

  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (cmd_fire) begin
      addr_q <= cmd_data[63:32];
      len_q  <= cmd_data[31:0];
      idx_q  <= '0;
    end else if (wr_fire || issue) begin
      idx_q  <= idx_q + 32'd1;
    end
  end

  // NOTE: the array and its read register are left unreset so they map onto block RAM; contents survive reset.
  always_ff @(posedge clk_mem) begin
    if (mem_we) mem[mem_idx] <= wr_data;
    if (issue)  ram_q <= mem[mem_idx];
  end

  // Two-entry skid buffer: rd_data is the head, skid_q the second entry.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      cnt_q   <= 2'd0;
      rd_data <= '0;
      skid_q  <= '0;
    end else begin
      pend_q <= issue;
      case ({pend_q, rd_fire})
        2'b10: begin
          if (cnt_q == 2'd0) rd_data <= push_data;
          else               skid_q  <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) rd_data <= skid_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            rd_data <= skid_q;
            skid_q  <= push_data;
          end else begin
            rd_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_bram_responder.md
# mem_bram_responder

Synthesizable responder for the memory command/data protocol that `da_platform` issues on `clk_mem`. It accepts `MemoryCommand` words, services burst writes from the write-data FIFO into an on-chip block RAM, and streams burst reads back on the read-data FIFO. It stands in for the MIG+DDR3 pair in small-footprint builds and in bring-up. It is also the synthesizable counterpart to the bench memory model.

## Interface
- `mem_width`, default 32: data word width.
- `mem_log_depth`, default 12: log2 of BRAM depth in words.
- `clk_mem` input 1: clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low.
- `cmd_valid` input 1: command word offered.
- `cmd_ready` output 1: responder accepts a command.
- `cmd_data` input 65: `[64]` read_not_write, `[63:32]` address in words, `[31:0]` length in words.
- `wr_valid` input 1: write word offered.
- `wr_ready` output 1: responder accepts a write word.
- `wr_data` input `mem_width`: write word.
- `rd_valid` output 1: read word available.
- `rd_ready` input 1: consumer accepts the read word.
- `rd_data` output `mem_width`: read word.
- `busy` output 1: state is not IDLE.
- `addr_error` output 1: sticky out-of-range flag. Exists only under the bounds-check build; see Configuration.

## Operation
- A transfer on any channel occurs at the rising edge where valid && ready.
- FSM states:
  - IDLE: `cmd_ready`=1. On command transfer, latch address/length and set the word counter to 0.
    - length 0: stay in IDLE. No data moves.
    - read_not_write=1: go to READ.
    - read_not_write=0: go to WRITE.
  - WRITE: `wr_ready`=1.
    - Each transfer writes `wr_data` to BRAM[(address+i) mod 2^mem_log_depth], then i++.
    - When the transfer with i==length-1 occurs, go to IDLE.
  - READ: issue BRAM read for word i whenever the output stage has room.
    - The output stage is a 2-entry skid buffer, so `rd_ready` may drop at any cycle without losing data.
    - After the last word is issued, go to DRAIN.
  - DRAIN: wait until the skid buffer is empty, then go to IDLE.
- Address arithmetic: 32-bit sum `address+i`. The BRAM index is the low `mem_log_depth` bits, so the address wraps silently unless bounds checking is compiled in.
- Ordering: a new command is never accepted until the previous write is fully committed or the previous read is fully drained. Read-after-write is therefore always coherent.
- `cmd_ready`, `wr_ready` and `busy` are registered outputs decoded from state.
- Reset: the FSM is forced to IDLE, the skid buffer is emptied and counters are cleared. BRAM contents are not cleared.
- Reset mid-burst: the burst is abandoned. Words already written persist; unsent read words are discarded.

## Timing
- Reset values:
  - `cmd_ready`=0 while `reset` is low; 1 on the first edge after release.
  - `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `addr_error`=0.
- Command accepted at edge N:
  - `busy`=1 and `cmd_ready`=0 after edge N.
  - For a write, `wr_ready`=1 after edge N.
  - For a read, the first BRAM read is issued at N+1 and `rd_valid` is high after edge N+2.
- Throughput: one word per cycle on both write and read while the partner holds valid/ready high.
- Write of length L with continuous `wr_valid`: `cmd_ready` is back to 1 after edge N+L+1.
- Read of length L with `rd_ready` held high: the last word transfers at edge N+L+2 and `cmd_ready`=1 after edge N+L+3.
- Stall: with `rd_ready` low, at most 2 words are held. Issue resumes the cycle after space frees.
- `rd_data` is held stable while `rd_valid`=1 and `rd_ready`=0.

## Configuration
- `MEM_RESPONDER_BOUNDS_CHECK_EN`
  - Defined: any word with `address+i` ≥ 2^mem_log_depth, or with a 32-bit carry-out, is handled as follows:
    - Writes: the word is accepted and discarded.
    - Reads: the word returns 0.
    - `addr_error` is set and stays set until reset.
    - The handshakes and burst length are unchanged.
  - Undefined: the index wraps modulo depth and the `addr_error` port is absent.

## Test plan
- Write address 0x10, length 4, data 1,2,3,4; then read 0x10 length 4 -> `rd_data` 1,2,3,4 on 4 consecutive cycles; `cmd_ready` high after edge N+7 of the read.
- Command with length 0 (read and write) -> no `wr_ready`/`rd_valid` activity; `cmd_ready` stays 1 with no IDLE gap.
- Read length 16 with `rd_ready` toggling 1,0,0,1 pseudo-randomly -> all 16 words arrive in order, none duplicated or dropped.
- Write at address 2^mem_log_depth−2, length 4, data A,B,C,D:
  - Without the macro: BRAM[0]=C, BRAM[1]=D.
  - With `MEM_RESPONDER_BOUNDS_CHECK_EN`: reads of 0,1 keep their old values and `addr_error`=1.
- Assert `reset` low after the 3rd word of an 8-word write -> the first 3 words are readable after release; `cmd_ready`=1 on the first edge after release; `busy`=0.
- Back-to-back write 0x20 len 2 then read 0x20 len 2 with `cmd_valid` held -> the read returns the freshly written data.
